// File: rtl/dram_rmw.sv
// dram_rmw -- single-port word memory with read-modify-write for sub-word stores.
//
// A core issues one access at a time. Loads return the full aligned word;
// word stores write directly; byte/half stores read the target word, merge
// the new lane(s) and write the merged word back. The response word and error
// flag are presented with a one-cycle resp_valid pulse and then held until
// the next response.
//
// Optional feature macro: DRAM_MISALIGN_CHK_EN
//   defined   : misaligned half/word stores and word-misaligned loads fault
//               (IDLE->RESP, no write, resp_err=1, resp_rdata=0)
//   undefined : no faults; low address bits are dropped to force alignment
//
// Parameters
//   ADDR_W      word-address width, memory depth 2^ADDR_W x 32 bits
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   access request
//   req_ready   block is IDLE and accepts an access
//   req_we      1 store, 0 load
//   req_size    00 word, 01 half, 10 byte, 11 word
//   req_addr    byte address (bits above ADDR_W+1 ignored, address wraps)
//   req_wdata   store data, right-justified for byte/half
//   resp_valid  one-cycle completion pulse
//   resp_rdata  full aligned word (loaded or written)
//   resp_err    access faulted
//
// state | meaning
// IDLE  | waiting for an access, req_ready=1
// RD    | synchronous read of the target word
// MRG   | merge store lane(s) into the read word and write it back
// WR    | full word write
// RESP  | resp_valid pulse, return to IDLE

module dram_rmw #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        MRG  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    state_t state_q, state_d;

    logic              we_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] idx_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;
    logic              fault_q;
    logic [31:0]       rd_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic [31:0]       mem [2**ADDR_W];

    logic              accept;
    logic              req_fault;
    logic              req_is_word;
    logic              is_word_q;
    logic [31:0]       merged;
    logic [31:0]       resp_word;

    // Address bits above the word index are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign req_ready   = (state_q == IDLE);
    assign accept      = req_valid && req_ready;
    assign req_is_word = (req_size != SZ_HALF) && (req_size != SZ_BYTE);
    assign is_word_q   = (size_q != SZ_HALF) && (size_q != SZ_BYTE);

`ifdef DRAM_MISALIGN_CHK_EN
    always_comb begin
        req_fault = 1'b0;
        if (!req_we) begin
            req_fault = (req_addr[1:0] != 2'b00);
        end else if (req_size == SZ_HALF) begin
            req_fault = req_addr[0];
        end else if (req_size == SZ_BYTE) begin
            req_fault = 1'b0;
        end else begin
            req_fault = (req_addr[1:0] != 2'b00);
        end
    end
`else
    assign req_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_fault)                 state_d = RESP;
                    else if (req_we && req_is_word) state_d = WR;
                    else                           state_d = RD;
                end
            end
            RD:      state_d = we_q ? MRG : RESP;
            MRG:     state_d = RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and held response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            idx_q        <= '0;
            lane_q       <= 2'b00;
            wdata_q      <= '0;
            fault_q      <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                idx_q   <= req_addr[ADDR_W+1:2];
                lane_q  <= req_addr[1:0];
                wdata_q <= req_wdata;
                fault_q <= req_fault;
            end
            // Latch what RESP showed so the outputs hold until the next RESP.
            if (state_q == RESP) begin
                resp_rdata_q <= resp_word;
                resp_err_q   <= fault_q;
            end
        end
    end

    // Byte lane is lane_q[1:0]; half lane is lane_q[1] (lane_q[0] dropped).
    always_comb begin
        merged = rd_q;
        if (size_q == SZ_BYTE) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    // rd_q and wdata_q are stable through RESP, so the response word is
    // rebuilt combinationally there instead of being registered on entry.
    always_comb begin
        resp_word = '0;
        if (fault_q)        resp_word = '0;
        else if (!we_q)     resp_word = rd_q;
        else if (is_word_q) resp_word = wdata_q;
        else                resp_word = merged;
    end

    // Memory array: not reset; writes only happen in WR/MRG, which an async
    // reset leaves immediately, so an interrupted store never writes.
    always_ff @(posedge clk) begin
        if (state_q == RD) begin
            rd_q <= mem[idx_q];
        end
        if (state_q == WR) begin
            mem[idx_q] <= wdata_q;
        end else if (state_q == MRG) begin
            mem[idx_q] <= merged;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = (state_q == RESP) ? resp_word : resp_rdata_q;
    assign resp_err   = (state_q == RESP) ? fault_q   : resp_err_q;

endmodule

// File: tb/tb_dram_rmw.sv
module tb_dram_rmw;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_errors = 0;

    dram_rmw #(.ADDR_W(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic we, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee, input int el);
        vec_t v;
        v.name = nm; v.we = we; v.size = sz; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
    task automatic do_access(input vec_t v);
        int  lat;
        bit  got;
        chk({v.name, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_we    = v.we;
        req_size  = v.size;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
                lat = i;
            end
        end
        chk({v.name, ".latency"}, lat, v.exp_lat);
        chk({v.name, ".rdata"}, resp_rdata, v.exp_rdata);
        chk({v.name, ".err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
        @(negedge clk);
        chk({v.name, ".valid_one_cycle"}, {31'd0, resp_valid}, 32'd0);
        chk({v.name, ".rdata_hold"}, resp_rdata, v.exp_rdata);
        chk({v.name, ".err_hold"}, {31'd0, resp_err}, {31'd0, v.exp_err});
    endtask

    initial begin
        int pulses;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_size = 2'b00; req_addr = '0; req_wdata = '0;

        vecs.push_back(mk("st_deadbeef",  1, 2'b00, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2));
        vecs.push_back(mk("ld_10",        0, 2'b00, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2));
        vecs.push_back(mk("st_base_a",    1, 2'b00, 32'h20, 32'h11223344, 32'h11223344, 0, 2));
        vecs.push_back(mk("st_byte_22",   1, 2'b10, 32'h22, 32'h000000AB, 32'h11AB3344, 0, 3));
        vecs.push_back(mk("ld_20_byte",   0, 2'b00, 32'h20, 32'h0,        32'h11AB3344, 0, 2));
        vecs.push_back(mk("st_base_b",    1, 2'b00, 32'h20, 32'h11223344, 32'h11223344, 0, 2));
        vecs.push_back(mk("st_half_22",   1, 2'b01, 32'h22, 32'h0000CAFE, 32'hCAFE3344, 0, 3));
        vecs.push_back(mk("ld_20_half",   0, 2'b00, 32'h20, 32'h0,        32'hCAFE3344, 0, 2));
        vecs.push_back(mk("st_base_c",    1, 2'b00, 32'h20, 32'h11223344, 32'h11223344, 0, 2));
        vecs.push_back(mk("st_half_20",   1, 2'b01, 32'h20, 32'h0000CAFE, 32'h1122CAFE, 0, 3));
        vecs.push_back(mk("st_byte_23",   1, 2'b10, 32'h23, 32'hFFFFFF55, 32'h5522CAFE, 0, 3));
        vecs.push_back(mk("st_byte_20",   1, 2'b10, 32'h20, 32'h00000077, 32'h5522CA77, 0, 3));
`ifdef DRAM_MISALIGN_CHK_EN
        vecs.push_back(mk("st_half_21",   1, 2'b01, 32'h21, 32'h1234BEEF, 32'h0,        1, 1));
        vecs.push_back(mk("ld_20_after",  0, 2'b00, 32'h20, 32'h0,        32'h5522CA77, 0, 2));
`else
        vecs.push_back(mk("st_half_21",   1, 2'b01, 32'h21, 32'h1234BEEF, 32'h5522BEEF, 0, 3));
        vecs.push_back(mk("ld_20_after",  0, 2'b00, 32'h20, 32'h0,        32'h5522BEEF, 0, 2));
`endif
        vecs.push_back(mk("st_size11_30", 1, 2'b11, 32'h30, 32'h01020304, 32'h01020304, 0, 2));
        vecs.push_back(mk("ld_wrap_1030", 0, 2'b00, 32'h1030, 32'h0,      32'h01020304, 0, 2));
`ifdef DRAM_MISALIGN_CHK_EN
        vecs.push_back(mk("st_word_33",   1, 2'b00, 32'h33, 32'hA5A5A5A5, 32'h0,        1, 1));
        vecs.push_back(mk("ld_31",        0, 2'b00, 32'h31, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk("ld_30",        0, 2'b00, 32'h30, 32'h0,        32'h01020304, 0, 2));
        vecs.push_back(mk("st_byte_33",   1, 2'b10, 32'h33, 32'h000000EE, 32'hEE020304, 0, 3));
`else
        vecs.push_back(mk("st_word_33",   1, 2'b00, 32'h33, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 2));
        vecs.push_back(mk("ld_31",        0, 2'b00, 32'h31, 32'h0,        32'hA5A5A5A5, 0, 2));
        vecs.push_back(mk("ld_30",        0, 2'b00, 32'h30, 32'h0,        32'hA5A5A5A5, 0, 2));
        vecs.push_back(mk("st_byte_33",   1, 2'b10, 32'h33, 32'h000000EE, 32'hEEA5A5A5, 0, 3));
`endif

        // Reset state
        #12;
        chk("rst.ready", {31'd0, req_ready}, 32'd1);
        chk("rst.valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        chk("rst.err",   {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) do_access(vecs[i]);

        // Reset while the byte store sits in MRG: no write, no response.
        do_access(mk("st_base_40", 1, 2'b00, 32'h40, 32'h11223344, 32'h11223344, 0, 2));
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'h41; req_wdata = 32'h000000AB;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);  // RD
        @(negedge clk);  // MRG
        rst_n = 1'b0;
        #1;
        chk("midrst.valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst.ready", {31'd0, req_ready}, 32'd1);
        chk("midrst.rdata", resp_rdata, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("midrst.valid_held", {31'd0, resp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst.valid_after", {31'd0, resp_valid}, 32'd0);
            chk("midrst.ready_after", {31'd0, req_ready}, 32'd1);
        end
        do_access(mk("ld_40_after_rst", 0, 2'b00, 32'h40, 32'h0, 32'h11223344, 0, 2));

        // Back-to-back loads with req_valid held high.
        pulses = 0;
        req_we = 1'b0; req_size = 2'b00; req_addr = 32'h10; req_valid = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge clk);
            if (k <= 9)
                chk($sformatf("b2b.ready[%0d]", k), {31'd0, req_ready},
                    {31'd0, (k % 3) == 0});
            chk($sformatf("b2b.valid[%0d]", k), {31'd0, resp_valid},
                {31'd0, ((k % 3) == 2) && (k <= 8)});
            if (resp_valid) begin
                pulses++;
                chk("b2b.rdata", resp_rdata, 32'hDEADBEEF);
            end
            if (k == 8) req_valid = 1'b0;
        end
        chk("b2b.pulses", pulses, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
